l1_cache: RTL and testbench



---
 rtl/lc3b_types.sv | 40 ++++
 rtl/cache_control.sv | 73 +++++++
 rtl/l1_cache.sv | 110 +++++++++++
 tb/tb_l1_cache.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
//------------------------------------------------------------------------------
// Module      : lc3b_types (package)
// Description : Shared LC-3b types and L1 cache geometry constants.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [2:0]   lc3b_c_offset;
  typedef logic [127:0] lc3b_c_line;

  localparam int unsigned c_num_lines  = 8;
  localparam int unsigned c_tag_msb    = 15;
  localparam int unsigned c_tag_lsb    = 7;
  localparam int unsigned c_index_msb  = 6;
  localparam int unsigned c_index_lsb  = 4;
  localparam int unsigned c_offset_msb = 3;
  localparam int unsigned c_offset_lsb = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } cache_state_t;

  // Byte-masked replacement of a stored word.
  function automatic lc3b_word word_merge(input lc3b_word old_word,
                                          input lc3b_word new_word,
                                          input logic [1:0] byte_en);
    word_merge[15:8] = byte_en[1] ? new_word[15:8] : old_word[15:8];
    word_merge[7:0]  = byte_en[0] ? new_word[7:0]  : old_word[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_control.sv
//------------------------------------------------------------------------------
// Module      : cache_control
// Description : IDLE/WRITEBACK/FILL sequencer for the L1 cache.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hit,
  input  logic dirty,
  input  logic mem_read,
  input  logic mem_write,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_word,
  output logic load_fill,
  output logic addr_sel_stored
);

  cache_state_t r_state;
  cache_state_t w_next_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state    = r_state;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    load_word       = 1'b0;
    load_fill       = 1'b0;
    addr_sel_stored = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            mem_resp  = 1'b1;
            load_word = mem_write;
          end else if (dirty) begin
            w_next_state = ST_WRITEBACK;
          end else begin
            w_next_state = ST_FILL;
          end
        end
      end
      ST_WRITEBACK: begin
        pmem_write      = 1'b1;
        addr_sel_stored = 1'b1;
        if (pmem_resp) w_next_state = ST_FILL;
      end
      ST_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_fill    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/l1_cache.sv
//------------------------------------------------------------------------------
// Module      : l1_cache
// Description : Direct-mapped write-back/write-allocate cache, 8 x 16-byte lines.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module l1_cache
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  logic [c_num_lines-1:0] r_valid;
  logic [c_num_lines-1:0] r_dirty;
  lc3b_c_tag              r_tag  [c_num_lines];
  lc3b_c_line             r_data [c_num_lines];

  lc3b_c_tag    w_tag;
  lc3b_c_index  w_index;
  lc3b_c_offset w_offset;
  lc3b_c_line   w_line;
  lc3b_c_line   w_merged_line;
  lc3b_word     w_word;
  logic         w_hit;
  logic         w_dirty;
  logic         w_load_word;
  logic         w_load_fill;
  logic         w_addr_sel_stored;
  logic         w_unused_addr_bit;

  assign w_tag             = mem_address[c_tag_msb:c_tag_lsb];
  assign w_index           = mem_address[c_index_msb:c_index_lsb];
  assign w_offset          = mem_address[c_offset_msb:c_offset_lsb];
  assign w_unused_addr_bit = mem_address[0];

  assign w_line  = r_data[w_index];
  assign w_word  = w_line[{w_offset, 4'b0000} +: 16];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_dirty = r_valid[w_index] && r_dirty[w_index];

  always_comb begin
    w_merged_line = w_line;
    w_merged_line[{w_offset, 4'b0000} +: 16] = word_merge(w_word, mem_wdata, mem_byte_enable);
  end

  cache_control u_control (
    .clk             (clk),
    .reset           (reset),
    .hit             (w_hit),
    .dirty           (w_dirty),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .pmem_resp       (pmem_resp),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .load_word       (w_load_word),
    .load_fill       (w_load_fill),
    .addr_sel_stored (w_addr_sel_stored)
  );

  // Data-path outputs are forced to zero whenever they carry no transaction.
  assign mem_rdata    = (mem_resp && !mem_write) ? w_word : 16'h0000;
  assign pmem_wdata   = pmem_write ? w_line : '0;
  assign pmem_address = (pmem_read || pmem_write)
                      ? {(w_addr_sel_stored ? r_tag[w_index] : w_tag), w_index, 4'b0000}
                      : 16'h0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_load_fill) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_load_word && (mem_byte_enable != 2'b00)) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_load_fill) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= pmem_rdata;
      end else if (w_load_word) begin
        r_data[w_index] <= w_merged_line;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_l1_cache.sv
//------------------------------------------------------------------------------
// Module      : tb_l1_cache
// Description : Directed self-checking bench for l1_cache.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_l1_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_total = 0;
  int n_bad   = 0;

  logic [127:0] r_line1;
  logic [127:0] r_line2;
  logic [127:0] r_dirty_line;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_line(input logic [15:0] base);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[16*w +: 16] = base + 16'(w);
    return l;
  endfunction

  // Called mid-cycle while the cache is in WRITEBACK or FILL; answers after delay cycles.
  task automatic pmem_phase(input string nm, input int delay, input logic exp_write,
                            input logic [15:0] exp_addr, input logic [127:0] exp_wdata,
                            input logic [127:0] line);
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin
        pmem_rdata = line;
        pmem_resp  = 1'b1;
      end
      #1;
      check({nm, "_pmem_read"},  pmem_read,  !exp_write);
      check({nm, "_pmem_write"}, pmem_write, exp_write);
      check({nm, "_pmem_addr"},  pmem_address, exp_addr);
      check({nm, "_mem_resp"},   mem_resp, 1'b0);
      if (exp_write) check({nm, "_pmem_wdata"}, pmem_wdata, exp_wdata);
      tick();
    end
    pmem_resp = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr);
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    mem_address = addr;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] be);
    mem_read        = 1'b0;
    mem_write       = 1'b1;
    mem_address     = addr;
    mem_wdata       = data;
    mem_byte_enable = be;
  endtask

  initial begin
    r_line1      = mk_line(16'h1110);
    r_line2      = mk_line(16'h2220);
    r_dirty_line = r_line1;
    r_dirty_line[16*3 +: 16] = 16'h11CD;
    r_dirty_line[16*4 +: 16] = 16'h5A14;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = 16'h0000; mem_wdata = 16'h0000; pmem_rdata = '0; pmem_resp = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_mem_resp",   mem_resp, 1'b0);
    check("rst_pmem_read",  pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_addr",  pmem_address, 16'h0000);
    check("rst_pmem_wdata", pmem_wdata, 128'h0);
    check("rst_mem_rdata",  mem_rdata, 16'h0000);

    // Cold miss on 0x0042, clean fill.
    cpu_read(16'h0042);
    #1;
    check("cold_miss_resp", mem_resp, 1'b0);
    tick();
    pmem_phase("fill1", 0, 1'b0, 16'h0040, '0, r_line1);
    #1;
    check("fill1_resp",  mem_resp, 1'b1);
    check("fill1_rdata", mem_rdata, 16'h1111);
    check("fill1_nowb",  pmem_write, 1'b0);
    check("fill1_nord",  pmem_read, 1'b0);

    tick();
    cpu_read(16'h0044);
    #1;
    check("hit44_resp",  mem_resp, 1'b1);
    check("hit44_rdata", mem_rdata, 16'h1112);
    check("hit44_prd",   pmem_read, 1'b0);
    check("hit44_pwr",   pmem_write, 1'b0);

    tick();
    cpu_write(16'h0046, 16'hABCD, 2'b01);
    #1;
    check("wr46_resp", mem_resp, 1'b1);
    tick();
    cpu_write(16'h0044, 16'hFFFF, 2'b00);
    #1;
    check("wr44_mask0_resp", mem_resp, 1'b1);
    tick();
    cpu_write(16'h0048, 16'h5A00, 2'b10);
    #1;
    check("wr48_resp", mem_resp, 1'b1);

    tick();
    cpu_read(16'h0046);
    #1;
    check("rd46_resp",  mem_resp, 1'b1);
    check("rd46_rdata", mem_rdata, 16'h11CD);
    tick();
    cpu_read(16'h0044);
    #1;
    check("rd44_rdata", mem_rdata, 16'h1112);
    tick();
    cpu_read(16'h0048);
    #1;
    check("rd48_rdata", mem_rdata, 16'h5A14);

    // Conflict miss on a dirty line: writeback answered at once, fill after 5 cycles.
    tick();
    cpu_read(16'h00C0);
    #1;
    check("conf_miss_resp", mem_resp, 1'b0);
    tick();
    pmem_phase("wb", 0, 1'b1, 16'h0040, r_dirty_line, '0);
    pmem_phase("fill2", 5, 1'b0, 16'h00C0, '0, r_line2);
    #1;
    check("fill2_resp",  mem_resp, 1'b1);
    check("fill2_rdata", mem_rdata, 16'h2220);

    // Clean conflict miss goes straight to FILL; reset abandons it.
    tick();
    cpu_read(16'h0046);
    #1;
    check("clean_miss_resp", mem_resp, 1'b0);
    tick();
    #1;
    check("clean_miss_prd",  pmem_read, 1'b1);
    check("clean_miss_pwr",  pmem_write, 1'b0);
    check("clean_miss_addr", pmem_address, 16'h0040);
    reset    = 1'b1;
    mem_read = 1'b0;
    tick();
    reset     = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = r_line1;
    #1;
    check("midrst_prd",  pmem_read, 1'b0);
    check("midrst_addr", pmem_address, 16'h0000);
    check("midrst_resp", mem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("late_resp_prd", pmem_read, 1'b0);

    cpu_read(16'h00C0);
    #1;
    check("post_rst_miss", mem_resp, 1'b0);
    tick();
    pmem_phase("fill3", 1, 1'b0, 16'h00C0, '0, r_line2);
    #1;
    check("fill3_resp",  mem_resp, 1'b1);
    check("fill3_rdata", mem_rdata, 16'h2220);
    tick();
    mem_read = 1'b0;
    #1;
    check("idle_resp", mem_resp, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
